// File: rtl/h_alpha_packer_pkg.sv
// Shared definitions for the H/alpha frame packer.
//   state_e : packer FSM states
//   WORD_W  : width of one upstream stream word
//   cnt_w   : counter width able to hold 0..max
package h_alpha_packer_pkg;

  localparam int unsigned WORD_W = 64;

  typedef enum logic [1:0] {
    S_H     = 2'd0,
    S_ALPHA = 2'd1,
    S_SKIP  = 2'd2
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned max);
    return $clog2(max) + 1;
  endfunction

endpackage

// File: rtl/h_alpha_packer_if.sv
// Stream and result bundle of the H/alpha frame packer.
//   s_tdata/s_tvalid/s_tlast/s_tready : upstream word stream (no backpressure in practice)
//   cfg_alpha_only                    : frame has no H section (sampled at frame start)
//   H_row*, alpha_u_col*              : unpacked H rows and alpha beats
//   frame_done/frame_err              : one-cycle frame status pulses
// modport slave is the packer side, modport master the producer/consumer side.
interface h_alpha_packer_if
  import h_alpha_packer_pkg::*;
#(
  parameter int unsigned J = 14
);
  logic [WORD_W-1:0]   s_tdata;
  logic                s_tvalid;
  logic                s_tlast;
  logic                s_tready;
  logic                cfg_alpha_only;
  logic [J-1:0]        H_row;
  logic                H_row_tvalid;
  logic                H_row_tlast;
  logic [J*WORD_W-1:0] alpha_u_col;
  logic                alpha_u_col_tvalid;
  logic                alpha_u_col_tlast;
  logic                frame_done;
  logic                frame_err;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, cfg_alpha_only,
    output s_tready, H_row, H_row_tvalid, H_row_tlast,
    output alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast, frame_done, frame_err
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, cfg_alpha_only,
    input  s_tready, H_row, H_row_tvalid, H_row_tlast,
    input  alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast, frame_done, frame_err
  );
endinterface

// File: rtl/h_alpha_packer_col_shift_pack.sv
// col_shift_pack: Depth-entry serial-in/parallel-out word register.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero all entries (wins over load_en)
//   load_en    : shift din in
//   din        : incoming word
//   par        : all entries, entry k in bits [k*WORD_W +: WORD_W]
// Words enter at the top entry and move down, so after Depth loads the first
// word sits in entry 0.
module col_shift_pack
  import h_alpha_packer_pkg::*;
#(
  parameter int unsigned Depth = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    load_en,
  input  logic [WORD_W-1:0]       din,
  output logic [Depth*WORD_W-1:0] par
);

  localparam int unsigned ParW = Depth * WORD_W;

  logic [ParW-1:0] par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else if (clear) begin
      par_q <= '0;
    end else if (load_en) begin
      par_q <= (par_q >> WORD_W) | (ParW'(din) << ((Depth - 1) * WORD_W));
    end
  end

  assign par = par_q;

endmodule

// File: rtl/h_alpha_packer.sv
// h_alpha_packer: splits a word stream into I H rows followed by A alpha beats
// of J 64-bit columns each (or only the alpha beats in alpha-only frames).
//   clk, rst_n : clock, async active-low reset
//   bus        : h_alpha_packer_if slave (stream in, rows/beats/status out)
// Early s_tlast aborts the frame with frame_err; a missing s_tlast on the last
// expected word finishes the frame, flags frame_err and drops words up to the
// next s_tlast.
module h_alpha_packer
  import h_alpha_packer_pkg::*;
#(
  parameter int unsigned J = 14,
  parameter int unsigned I = 7,
  parameter int unsigned A = 2
) (
  input logic             clk,
  input logic             rst_n,
  h_alpha_packer_if.slave bus
);

  localparam int unsigned ColW = J * WORD_W;
  localparam int unsigned RowW = cnt_w(I);
  localparam int unsigned WrdW = cnt_w(J);
  localparam int unsigned BeatW = cnt_w(A);

  localparam logic [RowW-1:0]  RowLast  = RowW'(I - 1);
  localparam logic [WrdW-1:0]  WordLast = WrdW'(J - 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(A - 1);

  state_e            state_q;
  logic              first_q;   // next accepted word starts a new frame
  logic [RowW-1:0]   row_cnt_q;
  logic [WrdW-1:0]   word_cnt_q;
  logic [BeatW-1:0]  beat_cnt_q;
  logic              ready_q;
  logic [J-1:0]      h_row_q;
  logic              h_vld_q;
  logic              h_last_q;
  logic [ColW-1:0]   col_q;
  logic              col_vld_q;
  logic              col_last_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  state_e            cur_state;
  logic              row_last;
  logic              word_last;
  logic              beat_last;
  logic              frame_end;
  logic              pack_load;
  logic              pack_clear;
  logic [ColW-1:0]   pack_par;
  logic [ColW-1:0]   beat;

  assign accept    = bus.s_tvalid & ready_q;
  // Mode is taken from cfg_alpha_only only on the first word of a frame.
  assign cur_state = first_q ? (bus.cfg_alpha_only ? S_ALPHA : S_H) : state_q;
  assign row_last  = (row_cnt_q == RowLast);
  assign word_last = (word_cnt_q == WordLast);
  assign beat_last = (beat_cnt_q == BeatLast);
  assign frame_end = (cur_state == S_ALPHA) && word_last && beat_last;

  assign pack_load  = accept && (cur_state == S_ALPHA);
  assign pack_clear = accept && bus.s_tlast && !frame_end;

  // Completed beat: the J-1 stored columns plus the word arriving now.
  assign beat = (pack_par >> WORD_W) | (ColW'(bus.s_tdata) << ((J - 1) * WORD_W));

  col_shift_pack #(
    .Depth (J)
  ) u_col_shift_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pack_clear),
    .load_en (pack_load),
    .din     (bus.s_tdata),
    .par     (pack_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_H;
      first_q    <= 1'b1;
      row_cnt_q  <= '0;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
      ready_q    <= 1'b0;
      h_row_q    <= '0;
      h_vld_q    <= 1'b0;
      h_last_q   <= 1'b0;
      col_q      <= '0;
      col_vld_q  <= 1'b0;
      col_last_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      h_vld_q    <= 1'b0;
      h_last_q   <= 1'b0;
      col_vld_q  <= 1'b0;
      col_last_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (accept) begin
        first_q <= 1'b0;
        unique case (cur_state)
          S_H: begin
            h_row_q <= bus.s_tdata[J-1:0];
            h_vld_q <= 1'b1;
            if (row_last) begin
              h_last_q  <= 1'b1;
              row_cnt_q <= '0;
              state_q   <= S_ALPHA;
            end else begin
              row_cnt_q <= row_cnt_q + RowW'(1);
              state_q   <= S_H;
            end
            if (bus.s_tlast) begin
              err_q     <= 1'b1;
              first_q   <= 1'b1;
              row_cnt_q <= '0;
            end
          end
          S_ALPHA: begin
            state_q <= S_ALPHA;
            if (word_last) begin
              word_cnt_q <= '0;
              col_q      <= beat;
              col_vld_q  <= 1'b1;
              if (beat_last) begin
                col_last_q <= 1'b1;
                done_q     <= 1'b1;
                beat_cnt_q <= '0;
                if (bus.s_tlast) begin
                  first_q <= 1'b1;
                end else begin
                  // Overrun: frame is complete but the stream has not ended.
                  err_q   <= 1'b1;
                  state_q <= S_SKIP;
                end
              end else begin
                beat_cnt_q <= beat_cnt_q + BeatW'(1);
                if (bus.s_tlast) begin
                  err_q      <= 1'b1;
                  first_q    <= 1'b1;
                  beat_cnt_q <= '0;
                end
              end
            end else begin
              word_cnt_q <= word_cnt_q + WrdW'(1);
              if (bus.s_tlast) begin
                err_q      <= 1'b1;
                first_q    <= 1'b1;
                word_cnt_q <= '0;
                beat_cnt_q <= '0;
              end
            end
          end
          S_SKIP: begin
            state_q <= S_SKIP;
            if (bus.s_tlast) begin
              first_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_H;
            first_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.s_tready           = ready_q;
  assign bus.H_row              = h_row_q;
  assign bus.H_row_tvalid       = h_vld_q;
  assign bus.H_row_tlast        = h_last_q;
  assign bus.alpha_u_col        = col_q;
  assign bus.alpha_u_col_tvalid = col_vld_q;
  assign bus.alpha_u_col_tlast  = col_last_q;
  assign bus.frame_done         = done_q;
  assign bus.frame_err          = err_q;

endmodule

// File: tb/tb_h_alpha_packer.sv
module tb_h_alpha_packer;

  localparam int J = 14;
  localparam int I = 7;
  localparam int A = 2;
  localparam logic [63:0] HMASK = (64'd1 << J) - 64'd1;

  typedef struct packed {
    logic          h_vld;
    logic          h_last;
    logic [63:0]   h_row;
    logic          a_vld;
    logic          a_last;
    logic [J*64-1:0] a_col;
    logic          done;
    logic          err;
  } ev_t;

  logic clk;
  logic rst_n;

  h_alpha_packer_if #(.J(J)) bus ();

  h_alpha_packer #(
    .J (J),
    .I (I),
    .A (A)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  ev_t exp_q[$];
  int  exp_done = 0;
  int  done_seen = 0;

  // Reference model state: position of the next word within its frame.
  int              pos = 0;
  bit              skipping = 0;
  bit              aof = 0;
  logic [63:0]     colbuf [J];
  logic [J*64-1:0] held_col = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    skipping = 0;
    held_col = '0;
    exp_q.delete();
  endtask

  task automatic model_word(input logic [63:0] d, input bit last);
    ev_t e;
    int hlen, flen, k;
    e = '0;
    e.a_col = held_col;
    if (skipping) begin
      if (last) begin
        skipping = 0;
        pos = 0;
      end
      return;
    end
    if (pos == 0) aof = bus.cfg_alpha_only;
    hlen = aof ? 0 : I;
    flen = hlen + A * J;
    if (pos < hlen) begin
      e.h_vld  = 1'b1;
      e.h_row  = d & HMASK;
      e.h_last = (pos == I - 1);
    end else begin
      k = pos - hlen;
      colbuf[k % J] = d;
      if (k % J == J - 1) begin
        for (int c = 0; c < J; c++) held_col[c*64 +: 64] = colbuf[c];
        e.a_vld  = 1'b1;
        e.a_col  = held_col;
        e.a_last = (k / J == A - 1);
        e.done   = e.a_last;
      end
    end
    pos++;
    if (pos == flen) begin
      pos = 0;
      if (!last) begin
        e.err = 1'b1;
        skipping = 1;
      end
    end else if (last) begin
      e.err = 1'b1;
      pos = 0;
    end
    if (e.done) exp_done++;
    if (e.h_vld || e.a_vld || e.done || e.err) exp_q.push_back(e);
  endtask

  // Monitor: compares every cycle in which the DUT presents any output pulse.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.H_row_tvalid || bus.alpha_u_col_tvalid || bus.frame_done ||
                    bus.frame_err)) begin
        if (bus.frame_done) done_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output hv=%b av=%b done=%b err=%b want none t=%0t",
                   bus.H_row_tvalid, bus.alpha_u_col_tvalid, bus.frame_done, bus.frame_err,
                   $time);
        end else begin
          e = exp_q.pop_front();
          chk("H_row_tvalid", 64'(bus.H_row_tvalid), 64'(e.h_vld));
          chk("H_row_tlast", 64'(bus.H_row_tlast), 64'(e.h_last));
          if (e.h_vld) chk("H_row", 64'(bus.H_row), e.h_row);
          chk("alpha_tvalid", 64'(bus.alpha_u_col_tvalid), 64'(e.a_vld));
          chk("alpha_tlast", 64'(bus.alpha_u_col_tlast), 64'(e.a_last));
          chk("frame_done", 64'(bus.frame_done), 64'(e.done));
          chk("frame_err", 64'(bus.frame_err), 64'(e.err));
          for (int c = 0; c < J; c++) begin
            chk($sformatf("alpha_col%0d", c), bus.alpha_u_col[c*64 +: 64], e.a_col[c*64 +: 64]);
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_s_tready"}, 64'(bus.s_tready), 64'd0);
    chk({tag, "_H_row"}, 64'(bus.H_row), 64'd0);
    chk({tag, "_H_row_tvalid"}, 64'(bus.H_row_tvalid), 64'd0);
    chk({tag, "_H_row_tlast"}, 64'(bus.H_row_tlast), 64'd0);
    chk({tag, "_alpha_tvalid"}, 64'(bus.alpha_u_col_tvalid), 64'd0);
    chk({tag, "_alpha_tlast"}, 64'(bus.alpha_u_col_tlast), 64'd0);
    chk({tag, "_alpha_any"}, 64'(|bus.alpha_u_col), 64'd0);
    chk({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
    chk({tag, "_frame_err"}, 64'(bus.frame_err), 64'd0);
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [63:0] d, input bit last);
    int n;
    bit ok;
    n = 0;
    ok = 1;
    bus.s_tdata  = d;
    bus.s_tlast  = last;
    bus.s_tvalid = 1'b1;
    while (!bus.s_tready && ok) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        total++;
        bad++;
        $display("FAIL s_tready_timeout got=0 want=1 t=%0t", $time);
        ok = 0;
      end
    end
    if (ok) begin
      model_word(d, last);
      @(negedge clk);
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  // pat 0: H words 1..I then 100,101,...; pat 1: random. gap 1: toggle valid; gap 2: random idles.
  task automatic send_frame(input int n, input int tl, input int pat, input int gap);
    for (int w = 0; w < n; w++) begin
      logic [63:0] d;
      if (pat == 0) d = (w < I) ? 64'(w + 1) : 64'(100 + w - I);
      else d = {$urandom(), $urandom()};
      send_word(d, w == tl);
      if (gap == 1) @(negedge clk);
      else if (gap == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    bus.s_tdata        = '0;
    bus.s_tvalid       = 1'b0;
    bus.s_tlast        = 1'b0;
    bus.cfg_alpha_only = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Nominal frame, back-to-back.
    send_frame(I + A * J, I + A * J - 1, 0, 0);
    // Alpha-only frame.
    bus.cfg_alpha_only = 1'b1;
    send_frame(A * J, A * J - 1, 1, 0);
    bus.cfg_alpha_only = 1'b0;
    // Valid toggling 1,0,1,0.
    send_frame(I + A * J, I + A * J - 1, 0, 1);
    // Early tlast on word index 20, then a clean frame.
    send_frame(I + A * J, 20, 0, 0);
    send_frame(I + A * J, I + A * J - 1, 0, 0);
    // Overrun: no tlast on word 35, three extra words, then a clean frame.
    send_frame(I + A * J + 3, I + A * J + 2, 0, 0);
    send_frame(I + A * J, I + A * J - 1, 0, 0);

    // Reset after 10 words of a frame.
    send_frame(10, -1, 0, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(I + A * J, I + A * J - 1, 0, 0);

    // Random frames with random gaps and mode.
    for (int f = 0; f < 8; f++) begin
      int n;
      bus.cfg_alpha_only = 1'($urandom_range(0, 1));
      n = bus.cfg_alpha_only ? A * J : I + A * J;
      send_frame(n, n - 1, 1, 2);
    end
    bus.cfg_alpha_only = 1'b0;

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("frame_done_count", 64'(done_seen), 64'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
